// File: rtl/d_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory d_mem; every memory-side signal is registered.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port A wins ties.
module d_mem_arbiter #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              A_Req,
    input  logic              A_Write,
    input  logic [ADDR_W-1:0] A_Addr,
    input  logic [DATA_W-1:0] A_WData,
    output logic              A_Ack,
    output logic              A_Err,
    output logic [DATA_W-1:0] A_RData,
    input  logic              B_Req,
    input  logic              B_Write,
    input  logic [ADDR_W-1:0] B_Addr,
    input  logic [DATA_W-1:0] B_WData,
    output logic              B_Ack,
    output logic              B_Err,
    output logic [DATA_W-1:0] B_RData,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arbStateT;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    arbStateT          stateReg, stateNext;
    logic              grantB;
    logic              selWrite;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWData;
    logic              selRange;
    logic              winBReg;
    logic              latWriteReg;
    logic              latRangeReg;
    logic [DATA_W-1:0] loadData;

`ifdef ARB_ROUND_ROBIN_EN
    logic ptrBReg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptrBReg <= 1'b0;
        end else if (stateReg == IDLE && (A_Req || B_Req)) begin
            ptrBReg <= ~grantB;
        end
    end
`endif

    always_comb begin
        stateNext = stateReg;
`ifdef ARB_ROUND_ROBIN_EN
        grantB = B_Req & (~A_Req | ptrBReg);
`else
        grantB = B_Req & ~A_Req;
`endif
        selWrite = grantB ? B_Write : A_Write;
        selAddr  = grantB ? B_Addr  : A_Addr;
        selWData = grantB ? B_WData : A_WData;
        selRange = ({1'b0, selAddr} < DEPTH_EXT);
        case (stateReg)
            IDLE:    if (A_Req || B_Req) stateNext = ACCESS;
            ACCESS:  stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Stores and out-of-range accesses both return zero read data.
    assign loadData = (~latWriteReg & latRangeReg) ? ReadData : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            winBReg     <= 1'b0;
            latWriteReg <= 1'b0;
            latRangeReg <= 1'b0;
            MemWrite    <= 1'b0;
            MemRead     <= 1'b0;
            Address     <= '0;
            WriteData   <= '0;
            A_Ack       <= 1'b0;
            A_Err       <= 1'b0;
            A_RData     <= '0;
            B_Ack       <= 1'b0;
            B_Err       <= 1'b0;
            B_RData     <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (A_Req || B_Req) begin
                        winBReg     <= grantB;
                        latWriteReg <= selWrite;
                        latRangeReg <= selRange;
                        Address     <= selAddr;
                        WriteData   <= selWData;
                        MemWrite    <= selWrite & selRange;
                        MemRead     <= ~selWrite & selRange;
                    end
                end
                ACCESS: begin
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                    if (winBReg) begin
                        B_Ack   <= 1'b1;
                        B_Err   <= ~latRangeReg;
                        B_RData <= loadData;
                    end else begin
                        A_Ack   <= 1'b1;
                        A_Err   <= ~latRangeReg;
                        A_RData <= loadData;
                    end
                end
                DONE: begin
                    A_Ack <= 1'b0;
                    B_Ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_d_mem_arbiter.sv
// Self-checking bench for d_mem_arbiter: reset, table vectors, arbitration sequences and random traffic
// checked against a word-array reference model.
module tb_d_mem_arbiter;
    localparam int DEPTH = 256;

    logic        clk;
    logic        reset_n;
    logic        A_Req, A_Write, A_Ack, A_Err;
    logic [31:0] A_Addr, A_WData, A_RData;
    logic        B_Req, B_Write, B_Ack, B_Err;
    logic [31:0] B_Addr, B_WData, B_RData;
    logic        MemWrite, MemRead;
    logic [31:0] Address, WriteData, ReadData;

    d_mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .A_Req(A_Req), .A_Write(A_Write), .A_Addr(A_Addr), .A_WData(A_WData),
        .A_Ack(A_Ack), .A_Err(A_Err), .A_RData(A_RData),
        .B_Req(B_Req), .B_Write(B_Write), .B_Addr(B_Addr), .B_WData(B_WData),
        .B_Ack(B_Ack), .B_Err(B_Err), .B_RData(B_RData),
        .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(input int a);
        if (a == 1) return 32'h11;
        if (a == 2) return 32'h22;
        return 32'h1000 + a;
    endfunction

    // d_mem stand-in: combinational read, write on the rising edge.
    logic [31:0] dMem [DEPTH];
    bit          written [DEPTH];
    always @(posedge clk) begin
        if (MemWrite && Address < DEPTH) begin
            dMem[Address[7:0]]    <= WriteData;
            written[Address[7:0]] <= 1'b1;
        end
    end
    assign ReadData = (Address >= DEPTH) ? 32'h0 :
                      (written[Address[7:0]] ? dMem[Address[7:0]] : initVal(int'(Address[7:0])));

    int          wrCnt = 0, rdCnt = 0, badStrobe = 0;
    logic [31:0] lastWrAddr = '0, lastRdAddr = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (MemWrite) begin wrCnt++; lastWrAddr = Address; end
            if (MemRead)  begin rdCnt++; lastRdAddr = Address; end
            if ((MemWrite || MemRead) && Address >= DEPTH) badStrobe++;
            if (MemWrite && MemRead) badStrobe++;
        end
    end

    // Reference model: memory contents and the held Err/RData of each port.
    logic [31:0] refMem [DEPTH];
    logic        lastErrM [2];
    logic [31:0] lastRDataM [2];

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit port, input bit req, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (port) begin B_Req = req; B_Write = wr; B_Addr = addr; B_WData = wd; end
        else      begin A_Req = req; A_Write = wr; A_Addr = addr; A_WData = wd; end
    endtask

    task automatic clearModel();
        lastErrM[0] = 1'b0; lastErrM[1] = 1'b0;
        lastRDataM[0] = '0; lastRDataM[1] = '0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset_n = 1'b1;
        clearModel();
    endtask

    // One single-port transaction, started on a falling edge with the arbiter idle.
    task automatic runCheck(input string tag, input bit port, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] expRData, input logic expErr);
        int          lat, wr0, rd0, other;
        logic [31:0] rdata;
        logic        err, ackNow, inRange;
        inRange = (addr < DEPTH);
        other   = port ? 0 : 1;
        wr0 = wrCnt; rd0 = rdCnt;
        drive(port, 1'b1, wr, addr, wd);
        lat = 0; ackNow = 1'b0;
        while (!ackNow && lat < 20) begin
            @(negedge clk);
            lat++;
            ackNow = port ? B_Ack : A_Ack;
        end
        rdata = port ? B_RData : A_RData;
        err   = port ? B_Err : A_Err;
        drive(port, 1'b0, wr, addr, wd);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, rdata, expRData);
        check({tag, "_err"}, 32'(err), 32'(expErr));
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(port ? B_Ack : A_Ack), 32'd0);
        check({tag, "_write_strobes"}, 32'(wrCnt - wr0), 32'(wr && inRange));
        check({tag, "_read_strobes"}, 32'(rdCnt - rd0), 32'(!wr && inRange));
        if (wr && inRange)  check({tag, "_write_addr"}, lastWrAddr, addr);
        if (!wr && inRange) check({tag, "_read_addr"}, lastRdAddr, addr);
        check({tag, "_other_err_hold"}, 32'(other == 1 ? B_Err : A_Err), 32'(lastErrM[other]));
        check({tag, "_other_rdata_hold"}, other == 1 ? B_RData : A_RData, lastRDataM[other]);
        lastErrM[port]   = expErr;
        lastRDataM[port] = expRData;
        if (wr && inRange) refMem[addr[7:0]] = wd;
        $display("txn %s port=%s %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 tag, port ? "B" : "A", wr ? "store" : "load", addr, wd, rdata, err, lat);
    endtask

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] expRData;
        logic        expErr;
    } vecT;

    initial begin
        vecT         vecs [10];
        int          aCyc, bCyc, n, ackSeen;
        logic [31:0] aData, bData, expData;
        logic [5:0]  order, expOrder;
        bit          port, wr, err;
        logic [31:0] addr, wd;
        int          r;

        for (int i = 0; i < DEPTH; i++) refMem[i] = initVal(i);
        clearModel();
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset held with a pending request: everything stays at zero.
        #2 reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'd3, '0);
        repeat (3) @(negedge clk);
        check("rst_flags", {26'd0, MemWrite, MemRead, A_Ack, A_Err, B_Ack, B_Err}, 32'd0);
        check("rst_address", Address, 32'd0);
        check("rst_writedata", WriteData, 32'd0);
        check("rst_a_rdata", A_RData, 32'd0);
        check("rst_b_rdata", B_RData, 32'd0);
        reset_n = 1'b1;
        runCheck("rst_release", 1'b0, 1'b0, 32'd3, '0, 32'h1003, 1'b0);

        // Simultaneous loads right after reset: A first, B three cycles later.
        applyReset();
        drive(1'b0, 1'b1, 1'b0, 32'd1, '0);
        drive(1'b1, 1'b1, 1'b0, 32'd2, '0);
        aCyc = 0; bCyc = 0; aData = '0; bData = '0;
        for (int c = 1; c <= 20 && bCyc == 0; c++) begin
            @(negedge clk);
            if (A_Ack && aCyc == 0) begin aCyc = c; aData = A_RData; drive(1'b0, 1'b0, 1'b0, 32'd1, '0); end
            if (B_Ack && bCyc == 0) begin bCyc = c; bData = B_RData; drive(1'b1, 1'b0, 1'b0, 32'd2, '0); end
        end
        check("tie_a_cycle", 32'(aCyc), 32'd2);
        check("tie_b_cycle", 32'(bCyc), 32'd5);
        check("tie_a_rdata", aData, 32'h11);
        check("tie_b_rdata", bData, 32'h22);
        $display("txn tie A@%0d=%h B@%0d=%h", aCyc, aData, bCyc, bData);
        @(negedge clk);
        lastRDataM[0] = 32'h11; lastRDataM[1] = 32'h22;

        vecs[0] = '{1'b0, 1'b1, 32'd5,        32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 1'b0, 32'd5,        32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd256,      32'h12345678, 32'h0,        1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'd0,        32'h0,        32'h1000,     1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd255,      32'hCAFEF00D, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'd255,      32'h0,        32'hCAFEF00D, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'd256,      32'h0,        32'h0,        1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'd0,        32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'd0,        32'h0,        32'hA5A5A5A5, 1'b0};
        for (int i = 0; i < 10; i++)
            runCheck($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].addr,
                     vecs[i].wd, vecs[i].expRData, vecs[i].expErr);

        // Reset during ACCESS of a load: strobe drops at once, no Ack follows.
        drive(1'b0, 1'b1, 1'b0, 32'd7, '0);
        @(posedge clk);
        #1;
        check("midrst_read_before", 32'(MemRead), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
        check("midrst_ack", 32'(A_Ack), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd7, '0);
        @(negedge clk);
        reset_n = 1'b1;
        clearModel();
        ackSeen = 0;
        repeat (4) begin
            @(negedge clk);
            if (A_Ack || B_Ack) ackSeen++;
        end
        check("midrst_no_ack", 32'(ackSeen), 32'd0);
        runCheck("midrst_reissue", 1'b0, 1'b0, 32'd7, '0, refMem[7], 1'b0);

        // Continuous dual requests for six grants.
        applyReset();
        drive(1'b0, 1'b1, 1'b0, 32'd1, '0);
        drive(1'b1, 1'b1, 1'b0, 32'd2, '0);
        order = '0; n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (A_Ack) n++;
            if (B_Ack && n < 6) begin order[n] = 1'b1; n++; end
        end
`ifdef ARB_ROUND_ROBIN_EN
        expOrder = 6'b101010;
`else
        expOrder = 6'b000000;
`endif
        check("streak_grants", 32'(n), 32'd6);
        check("streak_order", 32'(order), 32'(expOrder));
        $display("txn streak order(bit=B)=%b", order);
        applyReset();

        // Random single-port traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            port = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            if (r == 0)      addr = $urandom | 32'h100;
            else if (r == 1) addr = DEPTH - 1;
            else if (r == 2) addr = DEPTH;
            else             addr = $urandom_range(0, DEPTH - 1);
            wd   = $urandom;
            err  = (addr >= DEPTH);
            expData = (!wr && !err) ? refMem[addr[7:0]] : 32'h0;
            runCheck($sformatf("rnd%0d", i), port, wr, addr, wd, expData, err);
        end

        check("strobe_sanity", 32'(badStrobe), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
